// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: the NOP word, instruction
// field slices, the PC step and the layout of one buffered fetch entry.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] PC_INC   = 32'd4;

    // One buffered fetch: instruction word plus the address it came from.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] w);
        return w[6:0];
    endfunction

    function automatic logic [2:0] funct_of(input logic [31:0] w);
        return w[14:12];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instruction, pc} entries with a flush that
// discards everything buffered; push and pop may coincide when full.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses and hands {inst, pc} to decode; redirects flush and drop in-flight data.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP      = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  inst_opcode,
    output logic [2:0]  inst_funct
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          fifo_empty;
    logic          fifo_full;
    logic          req_fire;
    logic          rsp_keep;
    logic          pop;
    logic [31:0]   redirect_target;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Valid/ready on both channels: a transfer happens in the cycle where valid
    // and ready are both high; a raised request holds until then unless redirected.
    assign occupancy      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep         = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign pop              = !fifo_empty && inst_ready && !redirect_valid;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign redirect_target  = redirect_pc & ~32'h3;
    assign push_entry       = '{word: imem_rsp_data, pc: rsp_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Every response still owed, including one landing now, is stale.
                pc     <= redirect_target;
                rsp_pc <= redirect_target;
                drop   <= outstanding_next;
            end else begin
                if (req_fire) pc <= pc + PC_INC;
                if (imem_rsp_valid) begin
                    if (drop != '0) drop <= drop - CW'(1);
                    else            rsp_pc <= rsp_pc + PC_INC;
                end
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign inst_valid  = !fifo_empty;
    assign inst        = fifo_empty ? NOP : head.word;
    assign inst_pc     = fifo_empty ? '0 : head.pc;
    assign inst_opcode = opcode_of(inst);
    assign inst_funct  = funct_of(inst);

    // The occupancy bound means a kept response never meets a full, unpopped FIFO.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model answers requests in order with
// random latency; a scoreboard predicts the presented instruction stream.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  inst_opcode;
    logic [2:0]  inst_funct;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode),
        .inst_funct     (inst_funct)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int          n_checks;
    int          n_pass;
    int          cyc;
    int          p_ready;
    int          p_rsp;
    int          p_inst_ready;
    int          p_redirect;
    bit          force_redir;
    logic [31:0] force_pc;

    logic [31:0] pend_addr[$];
    int          pend_when[$];
    logic [63:0] exp_q[$];
    logic [31:0] req_exp;
    int          in_flight;
    int          req_count;
    int          pop_count;
    bit          prev_wait;
    bit          prev_redirect;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B9) ^ 32'h2545_F491;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        @(negedge clk);
        cyc++;
        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        inst_ready     = ($urandom_range(0, 99) < p_inst_ready);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
        end else begin
            redirect_valid = ($urandom_range(0, 99) < p_redirect);
            redirect_pc    = $urandom;
        end
        if (pend_addr.size() > 0 && pend_when[0] <= cyc && $urandom_range(0, 99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr.pop_front());
            void'(pend_when.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic quiet_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        pend_addr.delete();
        pend_when.delete();
        req_exp       = RESET_PC;
        in_flight     = 0;
        req_count     = 0;
        prev_wait     = 1'b0;
        prev_redirect = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"}, imem_req_valid, 0);
        check({tag, "_req_addr"},  imem_req_addr,  RESET_PC);
        check({tag, "_inst_valid"}, inst_valid,    0);
        check({tag, "_inst"},       inst,          NOP);
        check({tag, "_inst_pc"},    inst_pc,       0);
    endtask

    task automatic set_knobs(input int r, input int s, input int i, input int d);
        p_ready = r; p_rsp = s; p_inst_ready = i; p_redirect = d;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (prev_redirect) check("inst_valid_after_redirect", inst_valid, 0);
                if (!inst_valid) begin
                    check("idle_inst", inst, NOP);
                    check("idle_opcode", inst_opcode, 7'h13);
                    check("idle_funct", inst_funct, 3'h0);
                end
                if (redirect_valid) begin
                    check("req_valid_in_redirect", imem_req_valid, 0);
                    exp_q.delete();
                    req_exp   = {redirect_pc[31:2], 2'b00};
                    prev_wait = 1'b0;
                end else begin
                    if (prev_wait) begin
                        check("req_valid_stable", imem_req_valid, 1);
                        check("req_addr_stable", imem_req_addr, prev_addr);
                    end
                    if (inst_valid && inst_ready) begin
                        pop_count++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_inst: got pc %h inst %h expected none (cycle %0d)",
                                     inst_pc, inst, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check("inst", inst, e[63:32]);
                            check("inst_pc", inst_pc, e[31:0]);
                            check("inst_opcode", inst_opcode, e[38:32]);
                            check("inst_funct", inst_funct, e[46:44]);
                        end
                    end
                    if (imem_req_valid && imem_req_ready) begin
                        check("req_addr", imem_req_addr, req_exp);
                        exp_q.push_back({mem_word(req_exp), req_exp});
                        pend_addr.push_back(imem_req_addr);
                        pend_when.push_back(cyc + 1);
                        req_exp = req_exp + 32'd4;
                        in_flight++;
                        req_count++;
                    end
                    prev_wait = imem_req_valid && !imem_req_ready;
                    prev_addr = imem_req_addr;
                end
                prev_redirect = redirect_valid;
                if (imem_rsp_valid) in_flight--;
                check("in_flight_bound", (in_flight <= DEPTH), 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; pop_count = 0;
        force_redir = 1'b0; force_pc = '0;
        set_knobs(0, 0, 0, 0);
        quiet_inputs();
        clear_model();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Decode stalled: only DEPTH fetches may be accepted.
        set_knobs(100, 100, 0, 0);
        repeat (12) cycle();
        #2;
        check("stall_req_count", req_count, DEPTH);
        check("stall_req_valid_low", imem_req_valid, 0);

        // Release decode, then hold memory off for three cycles.
        set_knobs(100, 100, 100, 0);
        repeat (20) cycle();
        set_knobs(0, 100, 100, 0);
        repeat (3) cycle();
        set_knobs(100, 100, 100, 0);
        repeat (10) cycle();

        // Two fetches in flight, then redirect to a misaligned target.
        set_knobs(100, 0, 100, 0);
        repeat (4) cycle();
        set_knobs(100, 100, 100, 0);
        force_redir = 1'b1; force_pc = 32'h0000_0103;
        cycle();
        force_redir = 1'b0;
        cycle();
        #2 check("redirect_next_addr", imem_req_addr, 32'h0000_0100);
        repeat (20) cycle();

        // Redirect into a streaming pipe (response and pop in the same cycle).
        force_redir = 1'b1; force_pc = 32'h0000_0400;
        cycle();
        force_redir = 1'b0;
        repeat (10) cycle();

        // Fetch across the top of the address space.
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF6;
        cycle();
        force_redir = 1'b0;
        repeat (20) cycle();

        // Reset with fetches in flight.
        set_knobs(100, 0, 100, 0);
        repeat (4) cycle();
        #3 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        set_knobs(0, 0, 0, 0);
        quiet_inputs();
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_knobs(100, 100, 100, 0);
        repeat (10) cycle();

        // Random traffic.
        set_knobs(70, 60, 70, 3);
        repeat (4000) cycle();
        set_knobs(100, 100, 100, 0);
        repeat (20) cycle();

        #2 check("progress", (pop_count > 500), 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch unit: the producer side of the decoder's opcode/funct inputs.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched instructions in a small FIFO and presents them, with their PC, to the decode/control stage over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction FIFO entries and maximum outstanding-plus-buffered fetches; must be ≥1.
- NOP, 32'h0000_0013, instruction word driven when no valid instruction is presented (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order, never earlier than the cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  32  target address; bits [1:0] ignored and treated as 0.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  address of inst.
- inst_opcode  out  7  inst[6:0], feeds decoder read_opcode.
- inst_funct  out  3  inst[14:12], feeds decoder read_funct.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - pc = RESET_PC; imem_req_valid = 0; imem_req_addr = RESET_PC.
  - FIFO empty; inst_valid = 0; inst = NOP; inst_pc = 0.
  - outstanding = 0; drop = 0.
  - All counters are cleared; a reset mid-fetch abandons everything in flight.
- Issue rule:
  - imem_req_valid = (outstanding + fifo_count < DEPTH) and not redirect_valid; imem_req_addr = pc.
  - Both are combinational from registered state, so the first request can be accepted in the first cycle after reset release.
  - On handshake: pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0x0), outstanding += 1.
  - Once asserted, imem_req_valid and imem_req_addr stay stable until the handshake completes, except on redirect.
- Response:
  - On imem_rsp_valid: outstanding -= 1.
  - If drop > 0, drop -= 1 and the data is discarded.
  - Otherwise, push {data, rsp_pc} into the FIFO. rsp_pc comes from a second counter that increments by 4 per kept response.
- Simultaneous request handshake and response in one cycle: outstanding is unchanged.
- Output side:
  - inst_valid = FIFO not empty; head entry drives inst, inst_pc, inst_opcode, inst_funct.
  - When empty, inst = NOP and inst_opcode/inst_funct are taken from NOP.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle are allowed when full (the pop frees the slot); the occupancy bound guarantees no overflow.
- Redirect (highest priority):
  - In the redirect cycle: FIFO flushed and any pop ignored; no request handshake (valid forced low).
  - Next-state: pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - drop = outstanding(next), i.e. including a response arriving that same cycle being dropped, so every in-flight response is discarded.
  - Fetching resumes the following cycle.
- Back-to-back redirects: each recomputes drop from the current outstanding; the last one wins.
- Counter widths: outstanding, drop, fifo_count are clog2(DEPTH+1) bits; no over/underflow is reachable with a compliant memory.
- States: implicit via counters; no FSM beyond FIFO pointers and counters. Invariant: fifo_count + outstanding ≤ DEPTH.

Decomposition:
- Shared defs:
  - NOP constant.
  - Opcode field slices INST_OPCODE = [6:0], INST_FUNCT = [14:12].
  - PC increment constant 4.
- Sub-module fetch_fifo: synchronous FIFO of DEPTH × 64 bits (inst + pc), with flush input, push/pop, and count/empty/full outputs.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, inst_ready = 1 → requests at 0x0, 0x4, 0x8…; inst_pc sequence 0x0, 0x4, 0x8; inst_opcode = data[6:0]; throughput reaches one instruction per cycle.
- inst_ready held 0 → after DEPTH = 2 responses, imem_req_valid drops to 0; no more than 2 requests accepted; releasing inst_ready resumes fetching at 0x8.
- Redirect to 0x103 with 2 requests outstanding → next request at 0x100; the 2 stale responses are discarded; first presented inst_pc = 0x100.
- Redirect in the same cycle as a response and as an inst pop → FIFO empties, the same-cycle response is dropped, and inst_valid = 0 the next cycle.
- imem_req_ready low for 3 cycles → imem_req_addr stable at 0x8 throughout; one handshake only.
- rst_n asserted mid-stream with 2 outstanding → all outputs return to reset values immediately, and fetching restarts at RESET_PC.
